reg_file_mp: RTL

- Parametrised multi-port register file; successor to the single-read/single-write register stack in the CPU datapath.
- Sits between decode and execute. Provides RD_PORTS registered read ports and two write ports (ALU result, load result).
- Adds same-cycle write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard (reserve/release) for hazard detection by issue logic.

---
 rtl/reg_file_mp_pkg.sv | 9 +
 rtl/reg_file_rdport.sv | 67 ++++++
 rtl/reg_file_mp.sv | 119 +++++++++++
 3 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared sizing constants for the multi-port register file and its read ports.
package reg_file_mp_pkg;

    localparam int RF_WORD_WIDTH  = 16;
    localparam int RF_NIB_WIDTH   = 4;
    localparam int REG_STACK_SIZE = 16;
    localparam int MAX_RD_PORTS   = 4;

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: merges same-edge writes/reserve into the stored
// value so the registered result matches the post-edge register state.
module reg_file_rdport
    import reg_file_mp_pkg::*;
#(
    parameter int WORD_WIDTH = RF_WORD_WIDTH,
    parameter int NIB_WIDTH  = RF_NIB_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rd_en,
    input  logic [NIB_WIDTH-1:0]  i_rd_num,
    input  logic [WORD_WIDTH-1:0] i_stored_val,
    input  logic                  i_stored_busy,
    input  logic                  i_wr0_ok,
    input  logic [NIB_WIDTH-1:0]  i_wr0_num,
    input  logic [WORD_WIDTH-1:0] i_wr0_val,
    input  logic                  i_wr1_ok,
    input  logic [NIB_WIDTH-1:0]  i_wr1_num,
    input  logic [WORD_WIDTH-1:0] i_wr1_val,
    input  logic                  i_rsv_ok,
    input  logic [NIB_WIDTH-1:0]  i_rsv_num,
    output logic [WORD_WIDTH-1:0] o_rd_val,
    output logic                  o_rd_busy
);

    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit_rsv;
    logic [WORD_WIDTH-1:0] w_val;
    logic                  w_busy;
    logic [WORD_WIDTH-1:0] r_val;
    logic                  r_busy;

    // The *_ok strobes already exclude out-of-range and hardwired-zero targets.
    always_comb begin
        w_hit0    = i_wr0_ok && (i_rd_num == i_wr0_num);
        w_hit1    = i_wr1_ok && (i_rd_num == i_wr1_num);
        w_hit_rsv = i_rsv_ok && (i_rd_num == i_rsv_num);
        w_val     = i_stored_val;
        if (w_hit1) begin
            w_val = i_wr1_val;
        end else if (w_hit0) begin
            w_val = i_wr0_val;
        end
        w_busy = i_stored_busy;
        if (w_hit_rsv) begin
            w_busy = 1'b1;
        end else if (w_hit0 || w_hit1) begin
            w_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= '0;
            r_busy <= 1'b0;
        end else if (i_rd_en) begin
            r_val  <= w_val;
            r_busy <= w_busy;
        end
    end

    assign o_rd_val  = r_val;
    assign o_rd_busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports, same-edge write-to-read
// bypass, optional hardwired zero register and a busy scoreboard.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int WORD_WIDTH = RF_WORD_WIDTH,
    parameter int NIB_WIDTH  = RF_NIB_WIDTH,
    parameter int REG_COUNT  = REG_STACK_SIZE,
    parameter int RD_PORTS   = 2,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [RD_PORTS-1:0]            rd_en,
    input  logic [RD_PORTS*NIB_WIDTH-1:0]  rd_num,
    output logic [RD_PORTS*WORD_WIDTH-1:0] rd_val,
    output logic [RD_PORTS-1:0]            rd_busy,
    input  logic                           wr0_en,
    input  logic [NIB_WIDTH-1:0]           wr0_num,
    input  logic [WORD_WIDTH-1:0]          wr0_val,
    input  logic                           wr1_en,
    input  logic [NIB_WIDTH-1:0]           wr1_num,
    input  logic [WORD_WIDTH-1:0]          wr1_val,
    input  logic                           rsv_en,
    input  logic [NIB_WIDTH-1:0]           rsv_num,
    output logic [REG_COUNT-1:0]           busy
);

    if (RD_PORTS < 1 || RD_PORTS > MAX_RD_PORTS) begin : g_bad_rd_ports
        $error("reg_file_mp: RD_PORTS out of range");
    end
    if (REG_COUNT > (1 << NIB_WIDTH)) begin : g_bad_reg_count
        $error("reg_file_mp: REG_COUNT exceeds register-number space");
    end

    logic [WORD_WIDTH-1:0] r_data [REG_COUNT];
    logic [REG_COUNT-1:0]  r_busy;
    logic [REG_COUNT-1:0]  w_busy_nxt;
    logic                  w_wr0_ok;
    logic                  w_wr1_ok;
    logic                  w_rsv_ok;

    // A register number that names real, writable storage.
    function automatic logic f_target_ok(input logic [NIB_WIDTH-1:0] num);
        return (32'(num) < 32'(REG_COUNT)) && !(ZERO_REG && (num == '0));
    endfunction

    assign w_wr0_ok = wr0_en && f_target_ok(wr0_num);
    assign w_wr1_ok = wr1_en && f_target_ok(wr1_num);
    assign w_rsv_ok = rsv_en && f_target_ok(rsv_num);

    // Reserve is applied last so a newly issued producer keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0_ok) w_busy_nxt[wr0_num] = 1'b0;
        if (w_wr1_ok) w_busy_nxt[wr1_num] = 1'b0;
        if (w_rsv_ok) w_busy_nxt[rsv_num] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_data[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr0_ok) r_data[wr0_num] <= wr0_val;
            if (w_wr1_ok) r_data[wr1_num] <= wr1_val;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [NIB_WIDTH-1:0]  w_num;
        logic                  w_ok;
        logic [WORD_WIDTH-1:0] w_stored_val;
        logic                  w_stored_busy;

        assign w_num         = rd_num[p*NIB_WIDTH +: NIB_WIDTH];
        assign w_ok          = f_target_ok(w_num);
        assign w_stored_val  = w_ok ? r_data[w_num] : '0;
        assign w_stored_busy = w_ok ? r_busy[w_num] : 1'b0;

        reg_file_rdport #(
            .WORD_WIDTH (WORD_WIDTH),
            .NIB_WIDTH  (NIB_WIDTH)
        ) u_rdport (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_rd_en       (rd_en[p]),
            .i_rd_num      (w_num),
            .i_stored_val  (w_stored_val),
            .i_stored_busy (w_stored_busy),
            .i_wr0_ok      (w_wr0_ok),
            .i_wr0_num     (wr0_num),
            .i_wr0_val     (wr0_val),
            .i_wr1_ok      (w_wr1_ok),
            .i_wr1_num     (wr1_num),
            .i_wr1_val     (wr1_val),
            .i_rsv_ok      (w_rsv_ok),
            .i_rsv_num     (rsv_num),
            .o_rd_val      (rd_val[p*WORD_WIDTH +: WORD_WIDTH]),
            .o_rd_busy     (rd_busy[p])
        );
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (w_wr0_ok) $display("regfile: wr0 r%0d <= %h", wr0_num, wr0_val);
            if (w_wr1_ok) $display("regfile: wr1 r%0d <= %h", wr1_num, wr1_val);
            if (w_rsv_ok) $display("regfile: reserve r%0d", rsv_num);
        end
    end
`endif

endmodule
